recolector_datos: RTL and testbench

- Collector that feeds the debug unit's state machine the 32-bit `recolector` word, one word at a time: first the MIPS register file, then the data memory.
- Sits between the datapath's debug read ports (register file, data memory) and the debug state machine.
- Advanced by the state machine's `restart_recolector`, `send_regs_recolector` and `enable_next_recolector` strobes.
- Holds each word stable while its four bytes are shipped over UART.

---
 rtl/recolector_datos.sv | 164 ++++++++++++++++
 tb/tb_recolector_datos.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recolector_datos.sv
// -----------------------------------------------------------------------------
// recolector_datos
//
// Collects debug words for the debug state machine, one 32-bit word at a time:
// first the register file, then the data memory. Each word is held stable in
// `recolector` (with `valid` high) until the state machine asks for the next
// one with `enable_next`. `send_regs` picks the source at that moment.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   restart      synchronous rewind to register 0 (priority over enable_next)
//   send_regs    source select sampled with enable_next (1 = regs, 0 = memory)
//   enable_next  single-cycle strobe, advance to the next word
//   reg_addr     register file debug read address
//   reg_data     register file debug read data (combinational from reg_addr)
//   mem_addr     data memory debug read address
//   mem_rd_en    data memory debug read enable (one cycle per word)
//   mem_data     data memory read data, valid the cycle after mem_rd_en
//   recolector   word currently presented
//   valid        recolector holds a stable, fresh word
//   done         both sources exhausted
//   word_count   words presented since the last restart or reset
// -----------------------------------------------------------------------------
module recolector_datos #(
    parameter int len            = 32,
    parameter int cant_regs      = 32,
    parameter int cant_mem_datos = 16,
    parameter int NB_reg_addr    = $clog2(cant_regs),
    parameter int NB_mem_addr    = $clog2(cant_mem_datos)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   send_regs,
    input  logic                   enable_next,
    output logic [NB_reg_addr-1:0] reg_addr,
    input  logic [len-1:0]         reg_data,
    output logic [NB_mem_addr-1:0] mem_addr,
    output logic                   mem_rd_en,
    input  logic [len-1:0]         mem_data,
    output logic [len-1:0]         recolector,
    output logic                   valid,
    output logic                   done,
    output logic [7:0]             word_count
);

    typedef enum logic [2:0] {
        LOAD_REG,
        MEM_ADDR,
        MEM_DATA,
        HOLD,
        DONE
    } state_t;

    localparam logic [NB_reg_addr-1:0] REG_LAST = NB_reg_addr'(cant_regs - 1);
    localparam logic [NB_mem_addr-1:0] MEM_LAST = NB_mem_addr'(cant_mem_datos - 1);

    state_t                 state_q, state_d;
    logic [NB_reg_addr-1:0] reg_ptr_q, reg_ptr_d;
    logic [NB_mem_addr-1:0] mem_ptr_q, mem_ptr_d;
    logic                   cur_is_mem_q, cur_is_mem_d;
    logic [len-1:0]         recolector_q, recolector_d;
    logic [7:0]             word_count_q, word_count_d;
    logic                   valid_q, done_q, mem_rd_en_q;

    // Next-state logic. Pointers only advance from HOLD and stop at their last
    // index by going to DONE, so they never wrap.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        state_d      = state_q;
        reg_ptr_d    = reg_ptr_q;
        mem_ptr_d    = mem_ptr_q;
        cur_is_mem_d = cur_is_mem_q;
        recolector_d = recolector_q;
        word_count_d = word_count_q;

        if (restart) begin
            // recolector keeps its old word until the next load.
            state_d      = LOAD_REG;
            reg_ptr_d    = '0;
            mem_ptr_d    = '0;
            cur_is_mem_d = 1'b0;
            word_count_d = '0;
        end else begin
            unique case (state_q)
                LOAD_REG: begin
                    recolector_d = reg_data;
                    cur_is_mem_d = 1'b0;
                    word_count_d = word_count_q + 8'd1;
                    state_d      = HOLD;
                end
                MEM_ADDR: state_d = MEM_DATA;
                MEM_DATA: begin
                    recolector_d = mem_data;
                    cur_is_mem_d = 1'b1;
                    word_count_d = word_count_q + 8'd1;
                    state_d      = HOLD;
                end
                HOLD: begin
                    if (enable_next) begin
                        if (send_regs) begin
                            if (reg_ptr_q == REG_LAST) begin
                                state_d = DONE;
                            end else begin
                                reg_ptr_d = reg_ptr_q + 1'b1;
                                state_d   = LOAD_REG;
                            end
                        end else if (!cur_is_mem_q) begin
                            // First memory word after registers: mem_ptr
                            // already points at it.
                            state_d = MEM_ADDR;
                        end else if (mem_ptr_q == MEM_LAST) begin
                            state_d = DONE;
                        end else begin
                            mem_ptr_d = mem_ptr_q + 1'b1;
                            state_d   = MEM_ADDR;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = LOAD_REG;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe, with no input-to-output combinational path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD_REG;
            reg_ptr_q    <= '0;
            mem_ptr_q    <= '0;
            cur_is_mem_q <= 1'b0;
            recolector_q <= '0;
            word_count_q <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            mem_rd_en_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state_q      <= state_d;
            reg_ptr_q    <= reg_ptr_d;
            mem_ptr_q    <= mem_ptr_d;
            cur_is_mem_q <= cur_is_mem_d;
            recolector_q <= recolector_d;
            word_count_q <= word_count_d;
            valid_q      <= (state_d == HOLD);
            done_q       <= (state_d == DONE);
            mem_rd_en_q  <= (state_d == MEM_ADDR);
        end
    end

    assign reg_addr   = reg_ptr_q;
    assign mem_addr   = mem_ptr_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign recolector = recolector_q;
    assign valid      = valid_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_recolector_datos.sv
// -----------------------------------------------------------------------------
// tb_recolector_datos
//
// Directed-then-random bench for recolector_datos. A transaction-level model
// tracks which register / memory word the collector should present next and
// how many words have been shown; the bench supplies a combinational register
// file and a one-cycle-latency data memory.
// -----------------------------------------------------------------------------
module tb_recolector_datos;

    localparam int NREG = 32;
    localparam int NMEM = 16;

    logic        clk = 1'b0;
    logic        reset, restart, send_regs, enable_next;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [3:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_data = '0;
    logic [31:0] recolector;
    logic        valid, done;
    logic [7:0]  word_count;

    logic [31:0] regs    [NREG];
    logic [31:0] mem_arr [NMEM];

    int checks = 0;
    int errors = 0;

    // Reference model: index of the current register / memory word, whether
    // the last word came from memory, words shown, and the expected word.
    int          m_rp, m_mp, m_cnt;
    bit          m_cm, m_done;
    logic [31:0] m_word;

    recolector_datos dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .send_regs   (send_regs),
        .enable_next (enable_next),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_data    (mem_data),
        .recolector  (recolector),
        .valid       (valid),
        .done        (done),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    assign reg_data = regs[reg_addr];

    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem_arr[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_restart();
        m_rp   = 0;
        m_mp   = 0;
        m_cm   = 1'b0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic model_load_reg();
        m_word = regs[m_rp];
        m_cm   = 1'b0;
        m_cnt++;
    endtask

    task automatic expect_hold(input string tag);
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_word"}, recolector, m_word);
        check({tag, "_count"}, word_count, 8'(m_cnt));
    endtask

    // One advance request from HOLD (or DONE). poke re-asserts enable_next
    // while the collector is busy loading; it must be dropped.
    task automatic request(input bit sel, input bit poke, input int gap);
        int kind; // 0 register word, 1 memory word, 2 becomes done, 3 already done
        if (m_done) kind = 3;
        else if (sel) begin
            if (m_rp == NREG - 1) kind = 2;
            else begin m_rp++; kind = 0; end
        end else if (!m_cm) kind = 1;
        else if (m_mp == NMEM - 1) kind = 2;
        else begin m_mp++; kind = 1; end

        send_regs   = sel;
        enable_next = 1'b1;
        tick();
        enable_next = 1'b0;
        case (kind)
            0: begin
                check("load_valid_low", valid, 1'b0);
                check("load_reg_addr", reg_addr, 32'(m_rp));
                enable_next = poke;
                tick();
                enable_next = 1'b0;
                model_load_reg();
                expect_hold("reg");
            end
            1: begin
                check("maddr_valid_low", valid, 1'b0);
                check("maddr_rd_en", mem_rd_en, 1'b1);
                check("maddr_addr", mem_addr, 32'(m_mp));
                enable_next = poke;
                tick();
                check("mdata_valid_low", valid, 1'b0);
                check("mdata_rd_en_low", mem_rd_en, 1'b0);
                tick();
                enable_next = 1'b0;
                m_word = mem_arr[m_mp];
                m_cm   = 1'b1;
                m_cnt++;
                expect_hold("mem");
                check("mem_addr_kept", mem_addr, 32'(m_mp));
            end
            default: begin
                m_done = 1'b1;
                check("done_flag", done, 1'b1);
                check("done_valid_low", valid, 1'b0);
                check("done_word", recolector, m_word);
                check("done_count", word_count, 8'(m_cnt));
            end
        endcase
        repeat (gap) tick();
        check("gap_valid", valid, m_done ? 1'b0 : 1'b1);
        check("gap_word", recolector, m_word);
    endtask

    task automatic do_restart(input int hold_cycles);
        restart = 1'b1;
        repeat (hold_cycles) begin
            tick();
            check("rst_valid_low", valid, 1'b0);
            check("rst_done_low", done, 1'b0);
            check("rst_count_zero", word_count, 8'd0);
            check("rst_word_kept", recolector, m_word);
            check("rst_reg_addr", reg_addr, 32'd0);
        end
        restart = 1'b0;
        model_restart();
        tick();
        model_load_reg();
        expect_hold("after_restart");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = 32'h100 + i;
        regs[0] = 32'hDEAD0000;
        for (int i = 0; i < NMEM; i++) mem_arr[i] = 32'hA000 + i;
        reset       = 1'b0;
        restart     = 1'b0;
        send_regs   = 1'b1;
        enable_next = 1'b0;
        m_word      = '0;
        model_restart();

        // Reset values
        repeat (2) tick();
        check("reset_valid", valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_word", recolector, 32'h0);
        check("reset_count", word_count, 8'd0);
        check("reset_reg_addr", reg_addr, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_rd_en", mem_rd_en, 1'b0);

        // First register word one cycle after release
        reset = 1'b1;
        tick();
        model_load_reg();
        expect_hold("first");
        check("first_literal", recolector, 32'hDEAD0000);
        check("first_reg_addr", reg_addr, 32'd0);

        // Walk the register file, then one more pulse reaches DONE
        for (int k = 1; k < NREG; k++) request(1'b1, k == 5, 8);
        check("reg31_literal", recolector, 32'h11F);
        request(1'b1, 1'b0, 8);
        check("regs_done_count", word_count, 8'd32);
        request(1'b0, 1'b0, 3);   // ignored in DONE

        // Restart held for two cycles, then registers 1..31 and all memory
        do_restart(2);
        for (int k = 1; k < NREG; k++) request(1'b1, 1'b0, 2);
        for (int j = 0; j < NMEM; j++) request(1'b0, j == 3, 4);
        check("mem15_literal", recolector, 32'hA00F);
        check("mem_done_count", word_count, 8'd48);
        request(1'b0, 1'b0, 3);
        check("mem_done_flag", done, 1'b1);

        // Restart together with enable_next while holding register 10
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        do_restart(1);
        for (int k = 1; k <= 10; k++) request(1'b1, 1'b0, 1);
        restart     = 1'b1;
        enable_next = 1'b1;
        send_regs   = 1'b1;
        tick();
        restart     = 1'b0;
        enable_next = 1'b0;
        check("re_valid_low", valid, 1'b0);
        check("re_count_zero", word_count, 8'd0);
        check("re_reg_addr", reg_addr, 32'd0);
        check("re_word_kept", recolector, m_word);
        model_restart();
        tick();
        model_load_reg();
        expect_hold("re_reg0");
        check("re_reg0_addr", reg_addr, 32'd0);

        // Asynchronous reset while the memory read is in flight
        send_regs   = 1'b0;
        enable_next = 1'b1;
        tick();
        enable_next = 1'b0;
        check("ar_rd_en_before", mem_rd_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", valid, 1'b0);
        check("ar_rd_en", mem_rd_en, 1'b0);
        check("ar_word", recolector, 32'h0);
        check("ar_count", word_count, 8'd0);
        tick();
        reset  = 1'b1;
        m_word = '0;
        model_restart();
        tick();
        model_load_reg();
        expect_hold("ar_reg0");

        // Random mix of register and memory requests
        for (int i = 0; i < NMEM; i++) mem_arr[i] = $urandom;
        do_restart(1);
        for (int n = 0; n < 80; n++) begin
            request(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1);
            if (m_done) do_restart(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
